// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Holds the architectural PC, fetches one instruction at a time from imem and
// presents it to decode. When decode accepts, the next PC supplied by the NPC
// block is loaded and the next fetch starts on the following cycle.
//
// Handshake semantics (decode side): instr_valid/instr are registered and stay
// stable while instr_valid=1 and instr_ready=0. A transfer happens on every
// cycle where instr_valid & instr_ready are both 1. instr_valid never depends
// combinationally on instr_ready.
// imem side: imem_req is a one-cycle strobe with imem_addr=pc. Only one request
// is outstanding. imem_rvalid is honoured only while waiting for that response.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   npc                 next PC, sampled only on the accept cycle
//   pc                  current PC register
//   imem_req/imem_addr  fetch request strobe and address (address == pc)
//   imem_rvalid/rdata   fetch response
//   instr_valid/instr   instruction presented to decode
//   instr_ready         decode accepts the presented instruction
//   fault, fault_code   sticky fault: 01 misaligned npc, 10 imem timeout
//   retired_cnt         number of accepted instructions (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired_cnt
);

  // Counter just wide enough to hold TIMEOUT-1.
  localparam int              CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   TMAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly.
  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  wait_cnt;

  logic load_instr;
  logic accept;
  logic set_timeout;
  logic set_misalign;
  logic cnt_clr;
  logic cnt_inc;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    load_instr   = 1'b0;
    accept       = 1'b0;
    set_timeout  = 1'b0;
    set_misalign = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      S_REQ: begin
        cnt_clr    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          load_instr = 1'b1;
          state_next = S_HOLD;
        end else if (wait_cnt == TMAX) begin
          set_timeout = 1'b1;
          state_next  = S_FAULT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          accept = 1'b1;
          // A misaligned target is still a retired instruction, but the PC
          // is not updated so the faulting fetch address stays visible.
          if (npc[1:0] != 2'b00) begin
            set_misalign = 1'b1;
            state_next   = S_FAULT;
          end else begin
            state_next = S_REQ;
          end
        end
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_FAULT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      retired_cnt <= 32'h0;
      wait_cnt    <= '0;
    end else begin
      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (load_instr) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end

      if (accept) begin
        instr_valid <= 1'b0;
        retired_cnt <= retired_cnt + 32'd1;
        if (!set_misalign) begin
          pc <= npc;
        end
      end

      if (set_timeout) begin
        fault      <= 1'b1;
        fault_code <= FC_TIMEOUT;
      end else if (set_misalign) begin
        fault      <= 1'b1;
        fault_code <= FC_MISALIGN;
      end
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit. Expected instruction words are pushed to
// exp_q when the imem response is driven and popped when decode sees
// instr_valid. PC and retired count are tracked by a small bench-side model.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          TIMEOUT  = 16;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired_cnt;

  pc_fetch_unit #(
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc        (npc),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .fault      (fault),
    .fault_code (fault_code),
    .retired_cnt(retired_cnt)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (inputs change and outputs are sampled 1ns after posedge)
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in S_REQ: check the request, then answer after wait_cycles idle
  // cycles in S_WAIT, and check the instruction presented to decode.
  task automatic fetch(input string tag, input logic [31:0] word, input int wait_cycles);
    logic [31:0] exp_word;
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, exp_pc);
    tick();
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    exp_q.push_back(word);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    for (int i = 0; i < 8 && !instr_valid; i++) begin
      tick();
    end
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_instr"}, instr, exp_word);
  endtask

  // One accept cycle with the given next PC; updates the bench model.
  task automatic accept(input logic [31:0] next_pc);
    instr_ready = 1'b1;
    npc         = next_pc;
    tick();
    instr_ready = 1'b0;
    npc         = 32'h0;
    exp_ret     = exp_ret + 32'd1;
    if (next_pc[1:0] == 2'b00) begin
      exp_pc = next_pc;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_code"}, {30'd0, fault_code}, 32'd0);
    check({tag, "_ret"}, retired_cnt, 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    npc         = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    exp_pc      = RESET_PC;
    exp_ret     = 32'd0;

    // T1 reset
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("t1_rst");
    rst_n = 1'b1;
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr", imem_addr, 32'h0000_3000);

    // T2 sequential fetch, response one cycle after request
    fetch("t2", 32'h2408_0001, 0);
    check("t2_pc_hold", pc, 32'h0000_3000);
    accept(exp_pc + 32'd4);
    check("t2_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("t2_pc", pc, 32'h0000_3004);
    check("t2_ret", retired_cnt, exp_ret);
    check("t2_req", {31'd0, imem_req}, 32'd1);
    check("t2_addr", imem_addr, 32'h0000_3004);

    // T3 backpressure with T4 spurious rvalid in S_HOLD
    fetch("t3", 32'h0000_0013, 2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hdead_beef;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      tick();
      check("t3_instr", instr, 32'h0000_0013);
      check("t3_valid", {31'd0, instr_valid}, 32'd1);
      check("t3_pc", pc, 32'h0000_3004);
      check("t3_req", {31'd0, imem_req}, 32'd0);
      check("t3_ret", retired_cnt, exp_ret);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    // T4 branch target
    accept(32'h0000_3040);
    check("t4_addr", imem_addr, 32'h0000_3040);
    check("t4_req", {31'd0, imem_req}, 32'd1);
    check("t4_ret", retired_cnt, exp_ret);

    // T5 misaligned next PC
    fetch("t5", 32'h0000_0093, $urandom_range(0, 3));
    accept(32'h0000_3042);
    check("t5_fault", {31'd0, fault}, 32'd1);
    check("t5_code", {30'd0, fault_code}, 32'd1);
    check("t5_pc", pc, 32'h0000_3040);
    check("t5_ret", retired_cnt, exp_ret);
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = (i == 1);
      tick();
      check("t5_noreq", {31'd0, imem_req}, 32'd0);
      check("t5_novalid", {31'd0, instr_valid}, 32'd0);
      check("t5_sticky", {30'd0, fault_code}, 32'd1);
    end
    imem_rvalid = 1'b0;

    // T6 timeout: 16 cycles in S_WAIT without a response
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_rst_a");
    exp_pc  = RESET_PC;
    exp_ret = 32'd0;
    tick();
    rst_n = 1'b1;
    check("t6_req", {31'd0, imem_req}, 32'd1);
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
    end
    check("t6_no_fault_yet", {31'd0, fault}, 32'd0);
    tick();
    check("t6_fault", {31'd0, fault}, 32'd1);
    check("t6_code", {30'd0, fault_code}, 32'd2);
    check("t6_noreq", {31'd0, imem_req}, 32'd0);

    // Reset, start a fresh fetch, then reset asynchronously in mid-S_WAIT
    #2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_rst_b");
    check("t6_rst_req", {31'd0, imem_req}, 32'd1);
    tick();
    rst_n = 1'b1;

    // Recovery after reset: one full instruction
    fetch("t6_rec", 32'h0040_0113, $urandom_range(0, 4));
    accept(exp_pc + 32'd4);
    check("t6_rec_pc", pc, 32'h0000_3004);
    check("t6_rec_ret", retired_cnt, 32'd1);

    check("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
